// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory responder's FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Decodes transfer size and low address bits into little-endian byte strobes
// and flags accesses that are not naturally aligned.
module ahb_byte_lane_dec
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] strb,
    output logic       misaligned
);

    always_comb begin
        strb       = 4'b0000;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: begin
                strb       = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            HSIZE_WORD: begin
                strb       = 4'b1111;
                misaligned = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: register-array backed, programmable wait states,
// two-cycle ERROR response for illegal size or misaligned accesses.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES - 1);

    state_e           state_q;
    logic [2:0]       wait_q;
    logic             write_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       strb_q;
    logic [31:0]      mem_q [DEPTH];

    logic [3:0] strb;
    logic       misaligned;
    logic       illegal;
    logic       accept;
    logic       unused_bits;

    ahb_byte_lane_dec u_lane_dec (
        .hsize      (hsize),
        .addr       (haddr[1:0]),
        .strb       (strb),
        .misaligned (misaligned)
    );

    assign illegal = (hsize > HSIZE_WORD) | misaligned;

    // Only take a new address phase while our own data phase is completing, so a
    // stray hready during our WAIT/ERR1 cycles can never overwrite live controls.
    assign accept = hsel & hready & htrans[1] & hreadyout;

    // Burst type, sequential/non-sequential distinction and address bits above
    // the offset have no effect: every beat is SINGLE and the index wraps.
    assign unused_bits = ^{hburst, htrans[0], haddr[31:IDX_W+2]};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            strb_q    <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end else begin
            case (state_q)
                StWait: begin
                    if (wait_q == 3'd0) begin
                        state_q   <= StData;
                        hreadyout <= 1'b1;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q   <= StErr2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                // StIdle, StData and StErr2 all end a data phase and may accept.
                default: begin
                    if (accept) begin
                        write_q <= hwrite;
                        idx_q   <= haddr[IDX_W+1:2];
                        strb_q  <= strb;
                        if (illegal) begin
                            state_q   <= StErr1;
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state_q   <= StData;
                            hreadyout <= 1'b1;
                            hresp     <= HRESP_OKAY;
                        end else begin
                            state_q   <= StWait;
                            wait_q    <= WAIT_INIT;
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        state_q   <= StIdle;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Write data is only valid in the data phase, so the commit happens at the
    // edge that closes StData; a following read then sees it with no bypass.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == StData && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        hrdata = '0;
        if (state_q == StData && !write_q) begin
            hrdata = mem_q[idx_q];
        end
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Memory-backed AHB-Lite responder: one of the four slave endpoints on the 2-master/4-slave bus, selected by the decoder through `hsel`. It captures address-phase controls, inserts a programmable number of wait states, and performs byte/halfword/word reads and writes to a local register array. Illegal accesses get a two-cycle ERROR response.

## Interface
- `DEPTH`, 16: number of 32-bit words. Power of two, 4..256.
- `WAIT_STATES`, 0: `hreadyout`-low cycles inserted per OKAY transfer, 0..7.
- `hclk` input 1: bus clock; all state changes on the rising edge.
- `hreset` input 1: reset, asynchronous and active-high.
- `hsel` input 1: slave select from the decoder.
- `haddr` input 32: byte address; the low `log2(DEPTH)+2` bits are the offset.
- `hwrite` input 1: 1 = write, 0 = read.
- `hsize` input 3: 000 byte, 001 halfword, 010 word; other codes are illegal.
- `hburst` input 3: accepted and ignored; each beat is handled as SINGLE.
- `htrans` input 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hready` input 1: bus-level ready; an address phase is sampled only when it is 1.
- `hwdata` input 32: write data, valid in the data phase.
- `hreadyout` output 1: slave ready; reset value 1.
- `hresp` output 1: 0 OKAY, 1 ERROR; reset value 0.
- `hrdata` output 32: read data; reset value 0.

## Operation
- **Accept condition:** `hsel & hready & htrans[1]` at a rising edge. On accept, register `hwrite`, `hsize`, the word index `haddr[log2(DEPTH)+1:2]`, and `haddr[1:0]`.
- **Error condition:** `hsize > 2`, or misalignment (halfword with `addr[0]=1`, word with `addr[1:0]≠0`).
- **FSM states:**
  - IDLE: `hreadyout=1`, `hresp=0`.
    - Legal accept with `WAIT_STATES>0` → WAIT, wait counter loaded with `WAIT_STATES-1`.
    - Legal accept with `WAIT_STATES=0` → DATA.
    - Illegal accept → ERR1.
    - Otherwise stays in IDLE.
  - WAIT: `hreadyout=0`, `hresp=0`. Counter decrements each cycle; at 0 → DATA.
  - DATA: `hreadyout=1`, `hresp=0`. This is the final data-phase cycle.
    - Write: commit at the closing edge using byte lanes.
    - Read: `hrdata` is the addressed word, taken combinationally from the array via the registered index.
    - A new accept in the same cycle is evaluated exactly as from IDLE (pipelined back-to-back).
    - Otherwise → IDLE.
  - ERR1: `hreadyout=0`, `hresp=1` → ERR2.
  - ERR2: `hreadyout=1`, `hresp=1`. A new accept is evaluated as from IDLE; otherwise → IDLE.
- **Byte lanes (little-endian):**
  - Byte: lane = `addr[1:0]`.
  - Halfword: lanes {1,0} or {3,2} by `addr[1]`.
  - Word: all four lanes.
  - Unselected bytes are unchanged.
- Reads always return the full 32-bit word. `hrdata=0` outside DATA-read cycles.
- IDLE/BUSY transfers and unselected cycles get zero-wait OKAY and leave memory untouched.
- ERROR transfers never write memory.
- Memory resets to all-zero.
- `hreset` mid-transfer aborts immediately: FSM → IDLE, outputs take their reset values, and any pending write is discarded.

## Timing
- **Address-phase latency:** accept at edge N; the data phase starts in cycle N..N+1.
- **OKAY transfer:** data phase lasts `WAIT_STATES+1` cycles; `hreadyout` is high only in the last one.
- **Write:** memory is updated at the edge that ends DATA.
- **Write followed by read:** a read whose data phase follows a write to the same word returns the new data. This needs no bypass, because the write commits before the read's DATA cycle.
- **ERROR transfer:** exactly 2 data-phase cycles, regardless of `WAIT_STATES`.
- **Sustained rate:** with `WAIT_STATES=0`, one transfer per cycle.
- **Address index:** address bits above the offset are ignored, so the index wraps modulo `DEPTH`.

## Structure
- Shared package `ahb_pkg` holds:
  - `HTRANS_IDLE/BUSY/NONSEQ/SEQ`
  - `HSIZE_BYTE/HALF/WORD`
  - `HRESP_OKAY/ERROR`
  - the FSM state encoding
- One sub-module, `ahb_byte_lane_dec`: combinational decode of `hsize` and `addr[1:0]` into a 4-bit write strobe plus a misalignment flag.

## Test plan
- **Reset defaults:** assert `hreset` → `hreadyout=1`, `hresp=0`, `hrdata=0`; a read of word 3 after release returns `0x00000000`.
- **Zero-wait word write/read:** `WAIT_STATES=0`, word write `0xDEADBEEF` to `0x08`, then read `0x08` back-to-back → `hrdata=0xDEADBEEF` in the cycle after the write's data phase.
- **Byte-lane merge:** after the word write above, byte write `0x55` to `0x0A` and halfword write `0x1234` to `0x08`, then read `0x08` → `0xDE551234`.
- **Wait states:** `WAIT_STATES=3`, read → `hreadyout` low for 3 cycles, then high with the data.
- **Error response:** halfword at `0x01`, or `hsize=011` → `hreadyout` 0 then 1, with `hresp=1` in both cycles; memory unchanged on readback.
- **Bus idle cycles and mid-transfer reset:**
  - BUSY or `hsel=0` cycles → OKAY with zero wait.
  - `hreset` asserted during WAIT of a write to `0x04` → immediate defaults, and a later read of `0x04` returns 0.
